// File: rtl/mem_responder.sv
// mem_responder: single-word read/write memory answering after a fixed
// LAT-cycle access latency. It uses a valid/ready request handshake and a
// one-cycle rsp_valid pulse. Storage is not reset.
module mem_responder #(
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int LAT = 2   // legal 1..15, fits the 4-bit down-counter
) (
  input  logic          clk,
  input  logic          reset,      // synchronous, active-low
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          commit;

  logic [DW-1:0] mem_q [2**AW];

  // Next-state: accept in IDLE, count down in WAIT, commit on the WAIT->DONE edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = 4'(LAT - 1);
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          commit  = 1'b1;
          if (!we_q) rdata_d = mem_q[addr_q];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-request registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage write; reset has priority, so an aborted write never lands
  always_ff @(posedge clk) begin
    if (reset && commit && we_q) mem_q[addr_q] <= wdata_q;
  end

  // Outputs decode from state only (plus the reset gate on ready)
  assign req_ready = reset && (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;

endmodule
